// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 control sequencer.
package slc3_pkg;

    typedef enum logic [4:0] {
        StHalted,
        StFetch1,
        StFetch2,
        StFetch3,
        StDecode,
        StExecAlu,
        StBrEval,
        StBrTake,
        StJmp,
        StJsrLink,
        StJsrJump,
        StLdrAddr,
        StLdrMem,
        StLdrWb,
        StStrAddr,
        StStrData,
        StStrMem,
        StPauseIr1,
        StPauseIr2,
        StFault
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] DRMUX_IR = 2'b00;
    localparam logic [1:0] DRMUX_R7 = 2'b01;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    function automatic logic [1:0] alu_op(input logic [3:0] op);
        case (op)
            OP_AND:  return ALUK_AND;
            OP_NOT:  return ALUK_NOT;
            default: return ALUK_ADD;
        endcase
    endfunction

endpackage

// File: rtl/slc3_control_if.sv
// Control bundle between the SLC-3 sequencer (master) and its datapath/memory (slave).
interface slc3_control_if;

    logic        run;
    logic        cont;
    logic [15:0] IR;
    logic        branch_enable;
    logic        mem_resp;

    logic        mem_read;
    logic        mem_write;
    logic        LD_PC;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        LD_IR;
    logic        LD_REG;
    logic        LD_CC;
    logic        LD_LED;
    logic        GatePC;
    logic        GateMDR;
    logic        GateALU;
    logic        GateMARMUX;
    logic [1:0]  PCMUX;
    logic [1:0]  DRMUX;
    logic        SR1MUX;
    logic        SR2MUX;
    logic        ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic        MARMUX;
    logic        MIO_EN;
    logic [1:0]  ALUK;
    logic        fault;

    modport master (
        input  run, cont, IR, branch_enable, mem_resp,
        output mem_read, mem_write, LD_PC, LD_MAR, LD_MDR, LD_IR, LD_REG, LD_CC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
               ADDR1MUX, ADDR2MUX, MARMUX, MIO_EN, ALUK, fault
    );

    modport slave (
        output run, cont, IR, branch_enable, mem_resp,
        input  mem_read, mem_write, LD_PC, LD_MAR, LD_MDR, LD_IR, LD_REG, LD_CC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
               ADDR1MUX, ADDR2MUX, MARMUX, MIO_EN, ALUK, fault
    );

endinterface

// File: rtl/slc3_mem_wait.sv
// Memory-wait tracker: flags completion and expiry of the response wait window.
module slc3_mem_wait #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_resp,
    output logic done,
    output logic timeout
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] Last = (MEM_TIMEOUT > 0) ? CntW'(MEM_TIMEOUT - 1) : '0;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign done    = active & mem_resp;
    // Expires on the MEM_TIMEOUT-th waiting cycle so the strobe is high exactly that long.
    assign timeout = (MEM_TIMEOUT != 0) && active && !mem_resp && (cnt_q == Last);

    always_comb begin
        cnt_d = '0;
        if (active && !mem_resp) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/slc3_control.sv
// SLC-3 fetch/decode/execute sequencer; Moore outputs decoded from state and IR.
// Optional PAUSE instruction (opcode 1101) enabled by defining SLC3_PAUSE_EN.
module slc3_control
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic            clk,
    input logic            reset,
    slc3_control_if.master bus
);

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic       mem_active, mem_done, mem_timeout;

    assign opcode     = bus.IR[15:12];
    assign mem_active = (state_q == StFetch2) || (state_q == StLdrMem) || (state_q == StStrMem);

    slc3_mem_wait #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk     (clk),
        .reset   (reset),
        .active  (mem_active),
        .mem_resp(bus.mem_resp),
        .done    (mem_done),
        .timeout (mem_timeout)
    );

`ifdef SLC3_PAUSE_EN
    logic unused_ir;
    assign unused_ir = ^{bus.IR[11:6], bus.IR[4:0]};
`else
    logic unused_ir;
    assign unused_ir = ^{bus.IR[11:6], bus.IR[4:0], bus.cont};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = PCMUX_PC1;
        bus.DRMUX      = DRMUX_IR;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.ADDR2MUX   = ADDR2_ZERO;
        bus.MARMUX     = 1'b0;
        bus.MIO_EN     = 1'b0;
        bus.ALUK       = ALUK_ADD;
        bus.fault      = 1'b0;

        case (state_q)
            StHalted: if (bus.run) state_d = StFetch1;
            StFetch1: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                state_d    = StFetch2;
            end
            StFetch2, StLdrMem: begin
                bus.mem_read = 1'b1;
                bus.MIO_EN   = 1'b1;
                bus.LD_MDR   = mem_done;
                if (mem_timeout) begin
                    state_d = StFault;
                end else if (mem_done) begin
                    state_d = (state_q == StFetch2) ? StFetch3 : StLdrWb;
                end
            end
            StFetch3: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                state_d     = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: state_d = StExecAlu;
                    OP_BR:                  state_d = StBrEval;
                    OP_JMP:                 state_d = StJmp;
                    OP_JSR:                 state_d = StJsrLink;
                    OP_LDR:                 state_d = StLdrAddr;
                    OP_STR:                 state_d = StStrAddr;
`ifdef SLC3_PAUSE_EN
                    OP_PSE:                 state_d = StPauseIr1;
`endif
                    default:                state_d = StFetch1;
                endcase
            end
            StExecAlu: begin
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                bus.SR1MUX  = 1'b1;
                bus.SR2MUX  = bus.IR[5];
                bus.ALUK    = alu_op(opcode);
                state_d     = StFetch1;
            end
            StBrEval: state_d = bus.branch_enable ? StBrTake : StFetch1;
            StBrTake: begin
                bus.ADDR2MUX = ADDR2_OFF9;
                bus.PCMUX    = PCMUX_ADDER;
                bus.LD_PC    = 1'b1;
                state_d      = StFetch1;
            end
            StJmp: begin
                bus.SR1MUX   = 1'b1;
                bus.ADDR1MUX = 1'b1;
                bus.PCMUX    = PCMUX_ADDER;
                bus.LD_PC    = 1'b1;
                state_d      = StFetch1;
            end
            StJsrLink: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = DRMUX_R7;
                bus.LD_REG = 1'b1;
                state_d    = StJsrJump;
            end
            StJsrJump: begin
                bus.ADDR2MUX = ADDR2_OFF11;
                bus.PCMUX    = PCMUX_ADDER;
                bus.LD_PC    = 1'b1;
                state_d      = StFetch1;
            end
            StLdrAddr, StStrAddr: begin
                bus.SR1MUX     = 1'b1;
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = ADDR2_OFF6;
                bus.MARMUX     = 1'b1;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                state_d        = (state_q == StLdrAddr) ? StLdrMem : StStrData;
            end
            StLdrWb: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                state_d     = StFetch1;
            end
            StStrData: begin
                // Source register sits in IR[11:9]; ALU passes it through to MDR.
                bus.ALUK    = ALUK_PASSA;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                state_d     = StStrMem;
            end
            StStrMem: begin
                bus.mem_write = 1'b1;
                if (mem_timeout) begin
                    state_d = StFault;
                end else if (mem_done) begin
                    state_d = StFetch1;
                end
            end
`ifdef SLC3_PAUSE_EN
            StPauseIr1: begin
                bus.LD_LED = 1'b1;
                if (bus.cont) state_d = StPauseIr2;
            end
            StPauseIr2: if (!bus.cont) state_d = StFetch1;
`endif
            StFault: bus.fault = 1'b1;
            default: state_d = StHalted;
        endcase
    end

endmodule

// File: doc/slc3_control.md
Name: slc3_control

Overview:
- Fetch/decode/execute sequencer for the SLC-3 datapath.
- Drives every load enable, mux select, bus gate and ALU op on the datapath, and runs the memory read/write handshake.
- Inputs are IR and the branch-enable compare result. Sits beside the datapath inside the slc3 top.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for mem_resp in a memory state before entering FAULT; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- run  in  1  start execution from HALTED (level)
- cont  in  1  resume from PAUSE (level)
- IR  in  16  current instruction
- branch_enable  in  1  nzp & CC match from datapath
- mem_resp  in  1  memory access complete (one-cycle pulse)
- mem_read, mem_write  out  1  memory strobes, held until mem_resp
- LD_PC, LD_MAR, LD_MDR, LD_IR, LD_REG, LD_CC, LD_LED  out  1  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  out  1  bus drivers; at most one high in any cycle
- PCMUX  out  2  00 PC+1, 01 bus, 10 address adder
- DRMUX  out  2  00 IR[11:9], 01 R7
- SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
- SR2MUX  out  1  0 register, 1 sext(imm5), taken directly from IR[5]
- ADDR1MUX  out  1  0 PC, 1 SR1
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- MARMUX  out  1  0 PC, 1 adder
- MIO_EN  out  1  MDR source: 1 memory, 0 bus
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS-A
- fault  out  1  sticky; set on timeout

Behaviour:
- Reset (sync): state=HALTED; all outputs 0, including fault; timeout counter cleared. Reset mid-access drops mem_read/mem_write in the same edge.
- Outputs are Moore, decoded from state (plus IR fields), registered-state/combinational-decode.
- HALTED: wait for run=1, then FETCH1.
- FETCH1: GatePC, LD_MAR, PCMUX=00, LD_PC -> FETCH2.
- FETCH2: mem_read, MIO_EN, LD_MDR on the mem_resp cycle; stay until mem_resp -> FETCH3.
- FETCH3: GateMDR, LD_IR -> DECODE.
- DECODE: branch on IR[15:12]:
  - 0001 ADD / 0101 AND / 1001 NOT -> EXEC_ALU: GateALU, LD_REG, LD_CC, DRMUX=00, SR1MUX=1.
  - 0000 BR -> BR_EVAL. If branch_enable: BR_TAKE (ADDR1=PC, ADDR2=off9, PCMUX=10, LD_PC); else FETCH1.
  - 1100 JMP -> JMP: ADDR1=SR1, ADDR2=00, PCMUX=10, LD_PC.
  - 0100 JSR -> JSR_LINK (GatePC, DRMUX=01, LD_REG) -> JSR_JUMP (ADDR1=PC, ADDR2=off11, PCMUX=10, LD_PC).
  - 0110 LDR -> LDR_ADDR (ADDR1=SR1, ADDR2=off6, MARMUX=1, GateMARMUX, LD_MAR) -> LDR_MEM (as FETCH2) -> LDR_WB (GateMDR, LD_REG, LD_CC).
  - 0111 STR -> STR_ADDR (as LDR_ADDR) -> STR_DATA (SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR) -> STR_MEM (mem_write until mem_resp).
  - All other opcodes: NOP -> FETCH1.
- Each terminal execute state returns to FETCH1.
- LD_CC never asserts for STR, BR, JMP or JSR.
- Memory states: counter increments each waiting cycle. If MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT with no mem_resp: drop strobe, set fault, go to FAULT. FAULT is left only by reset.
- mem_resp outside a memory state is ignored.
- run going low does not stop execution. Only reset returns the block to HALTED.

Optional Feature:
- Macro SLC3_PAUSE_EN.
- When defined: opcode 1101 -> PAUSE_IR1. Assert LD_LED (LED shows IR[11:0]) and wait for cont=1. Then PAUSE_IR2: wait for cont=0, then FETCH1.
- When undefined: 1101 is a NOP; LD_LED tied 0; cont unused.

Decomposition:
- Package slc3_pkg holds:
  - state_t enum;
  - opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_LDR, OP_STR, OP_PSE);
  - mux-select localparams for PCMUX, DRMUX, ADDR2MUX, ALUK.
- One sub-module, slc3_mem_wait: timeout counter plus strobe hold; outputs done/timeout.

Test Plan:
- Reset during FETCH2 with mem_read=1 -> next cycle state=HALTED, mem_read=0, all LD_*=0.
- run=1, IR=16'h1261 (ADD R1,R1,#1), mem_resp 2 cycles after strobe -> LD_REG and LD_CC pulse once, SR2MUX=1, ALUK=00; total 6 cycles FETCH1 to next FETCH1.
- IR=16'h0402 (BRz): branch_enable=1 -> BR_TAKE with PCMUX=10, ADDR2MUX=10. branch_enable=0 -> no LD_PC after FETCH1.
- IR=16'h7042 (STR R0,R1,#2) -> LD_MAR with MARMUX=1, then LD_MDR with MIO_EN=0, then mem_write held until mem_resp; LD_CC never asserted.
- MEM_TIMEOUT=4, mem_resp never asserted in FETCH2 -> mem_read deasserts after 4 cycles, fault=1, stays in FAULT until reset.
- SLC3_PAUSE_EN defined, IR=16'hD0AB -> LD_LED=1, held in PAUSE until cont=1, then waits for cont=0 before FETCH1. Undefined: same IR -> FETCH1 directly, LD_LED=0.
